// File: rtl/mc_line_arbiter.sv
// Memory-controller front end: serialises I-fills, D-fills and D-evictions onto one
// line-wide memory port, with static-region protection and a memory watchdog.
module mc_line_arbiter #(
    parameter int                ADDR_W       = 32,
    parameter int                LINE_W       = 512,
    parameter logic [ADDR_W-1:0] STATIC_BASE  = 32'h0001_0000,
    parameter logic [ADDR_W-1:0] STATIC_LIMIT = 32'h0001_FFFF,
    parameter int                TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cacheMissFetch,
    input  logic [ADDR_W-1:0] instrAddr,
    input  logic              cacheMissMemory,
    input  logic [ADDR_W-1:0] dataAddr,
    input  logic              dCacheEvict,
    input  logic [ADDR_W-1:0] evictAddr,
    input  logic [LINE_W-1:0] dCacheOut,
    output logic              memReq,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [LINE_W-1:0] memWData,
    input  logic              memAck,
    input  logic [LINE_W-1:0] memRData,
    output logic              mcInstrValid,
    output logic [LINE_W-1:0] mcInstrIn,
    output logic              mcDataValid,
    output logic [LINE_W-1:0] mcDataIn,
    output logic              evictDone,
    output logic              exception,
    output logic [1:0]        exCause,
    output logic [ADDR_W-1:0] exAddr,
    output logic [2:0]        o_dbg_state
);

    localparam int                OFF_W      = $clog2(LINE_W / 8);
    localparam int                WD_W       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0]   WD_LAST    = WD_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << OFF_W;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_EVICT  = 3'd1,
        S_FILL_I = 3'd2,
        S_FILL_D = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_last_d;
    logic [WD_W-1:0]     r_wd;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [LINE_W-1:0]   r_mem_wdata;
    logic                r_instr_valid;
    logic                r_data_valid;
    logic                r_evict_done;
    logic [LINE_W-1:0]   r_instr_line;
    logic [LINE_W-1:0]   r_data_line;
    logic                r_exception;
    logic [1:0]          r_ex_cause;
    logic [ADDR_W-1:0]   r_ex_addr;

    logic                w_busy;
    logic                w_in_static;
    logic                w_grant_evict;
    logic                w_grant_i;
    logic                w_grant_d;
    logic                w_grant;
    logic                w_prot_fault;
    logic                w_timeout;
    logic [ADDR_W-1:0]   w_grant_addr;

    assign w_busy      = (r_state == S_EVICT) || (r_state == S_FILL_I) || (r_state == S_FILL_D);
    assign w_in_static = (dataAddr >= STATIC_BASE) && (dataAddr <= STATIC_LIMIT);
    assign w_grant     = w_grant_evict || w_grant_i || w_grant_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_grant_evict = 1'b0;
        w_grant_i     = 1'b0;
        w_grant_d     = 1'b0;
        w_prot_fault  = 1'b0;
        w_timeout     = 1'b0;
        w_grant_addr  = '0;
        case (r_state)
            S_IDLE: begin
                // Writeback first so a dirty victim reaches memory before its replacement.
                if (dCacheEvict) begin
                    w_grant_evict = 1'b1;
                    w_grant_addr  = evictAddr;
                    w_next_state  = S_EVICT;
                end else if (cacheMissMemory && (!cacheMissFetch || !r_last_d)) begin
                    if (w_in_static) begin
                        w_prot_fault = 1'b1;
                        w_next_state = S_HALTED;
                    end else begin
                        w_grant_d    = 1'b1;
                        w_grant_addr = dataAddr;
                        w_next_state = S_FILL_D;
                    end
                end else if (cacheMissFetch) begin
                    w_grant_i    = 1'b1;
                    w_grant_addr = instrAddr;
                    w_next_state = S_FILL_I;
                end
            end
            S_EVICT, S_FILL_I, S_FILL_D: begin
                // An ack on the expiry cycle still completes the transaction.
                if (memAck) begin
                    w_next_state = S_IDLE;
                end else if ((TIMEOUT != 0) && (r_wd == WD_LAST)) begin
                    w_timeout    = 1'b1;
                    w_next_state = S_HALTED;
                end
            end
            S_HALTED: w_next_state = S_HALTED;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_d      <= 1'b0;
            r_wd          <= '0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_instr_valid <= 1'b0;
            r_data_valid  <= 1'b0;
            r_evict_done  <= 1'b0;
            r_instr_line  <= '0;
            r_data_line   <= '0;
            r_exception   <= 1'b0;
            r_ex_cause    <= 2'b00;
            r_ex_addr     <= '0;
        end else begin
            r_instr_valid <= (r_state == S_FILL_I) && memAck;
            r_data_valid  <= (r_state == S_FILL_D) && memAck;
            r_evict_done  <= (r_state == S_EVICT) && memAck;
            if ((r_state == S_FILL_I) && memAck) begin
                r_instr_line <= memRData;
            end
            if ((r_state == S_FILL_D) && memAck) begin
                r_data_line <= memRData;
            end
            if (w_grant) begin
                r_mem_addr <= w_grant_addr & ALIGN_MASK;
                r_mem_we   <= w_grant_evict;
                r_wd       <= '0;
                if (w_grant_evict) begin
                    r_mem_wdata <= dCacheOut;
                end
            end else if (w_busy) begin
                r_wd <= r_wd + WD_W'(1);
            end
            if (w_grant_i) begin
                r_last_d <= 1'b0;
            end else if (w_grant_d) begin
                r_last_d <= 1'b1;
            end
            if (w_prot_fault) begin
                r_exception <= 1'b1;
                r_ex_cause  <= 2'b01;
                r_ex_addr   <= dataAddr;
            end else if (w_timeout) begin
                r_exception <= 1'b1;
                r_ex_cause  <= 2'b10;
                r_ex_addr   <= r_mem_addr;
            end
        end
    end

    assign memReq       = w_busy;
    assign memWe        = r_mem_we && w_busy;
    assign memAddr      = r_mem_addr;
    assign memWData     = r_mem_wdata;
    assign mcInstrValid = r_instr_valid;
    assign mcInstrIn    = r_instr_line;
    assign mcDataValid  = r_data_valid;
    assign mcDataIn     = r_data_line;
    assign evictDone    = r_evict_done;
    assign exception    = r_exception;
    assign exCause      = r_ex_cause;
    assign exAddr       = r_ex_addr;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_mc_line_arbiter.sv
// Directed and randomized bench for mc_line_arbiter; a transaction-level model predicts
// each grant (kind + address) and the expected fill/evict completion.
module tb_mc_line_arbiter;

    localparam int          ADDR_W  = 32;
    localparam int          LINE_W  = 512;
    localparam int          TIMEOUT = 8;
    localparam logic [31:0] ALIGN   = 32'hFFFF_FFC0;

    logic              clk;
    logic              rst;
    logic              cacheMissFetch;
    logic [ADDR_W-1:0] instrAddr;
    logic              cacheMissMemory;
    logic [ADDR_W-1:0] dataAddr;
    logic              dCacheEvict;
    logic [ADDR_W-1:0] evictAddr;
    logic [LINE_W-1:0] dCacheOut;
    logic              memReq;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [LINE_W-1:0] memWData;
    logic              memAck;
    logic [LINE_W-1:0] memRData;
    logic              mcInstrValid;
    logic [LINE_W-1:0] mcInstrIn;
    logic              mcDataValid;
    logic [LINE_W-1:0] mcDataIn;
    logic              evictDone;
    logic              exception;
    logic [1:0]        exCause;
    logic [ADDR_W-1:0] exAddr;
    logic [2:0]        dbg_state;

    int                n_vec = 0;
    int                n_err = 0;
    logic              m_last_d;
    logic [33:0]       exp_q[$];
    logic [LINE_W-1:0] exp_i_line;
    logic [LINE_W-1:0] exp_d_line;
    logic [LINE_W-1:0] exp_wdata;
    logic [LINE_W-1:0] line_a;

    mc_line_arbiter #(
        .ADDR_W      (ADDR_W),
        .LINE_W      (LINE_W),
        .STATIC_BASE (32'h0001_0000),
        .STATIC_LIMIT(32'h0001_FFFF),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cacheMissFetch (cacheMissFetch),
        .instrAddr      (instrAddr),
        .cacheMissMemory(cacheMissMemory),
        .dataAddr       (dataAddr),
        .dCacheEvict    (dCacheEvict),
        .evictAddr      (evictAddr),
        .dCacheOut      (dCacheOut),
        .memReq         (memReq),
        .memWe          (memWe),
        .memAddr        (memAddr),
        .memWData       (memWData),
        .memAck         (memAck),
        .memRData       (memRData),
        .mcInstrValid   (mcInstrValid),
        .mcInstrIn      (mcInstrIn),
        .mcDataValid    (mcDataValid),
        .mcDataIn       (mcDataIn),
        .evictDone      (evictDone),
        .exception      (exception),
        .exCause        (exCause),
        .exAddr         (exAddr),
        .o_dbg_state    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not reach its end");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] l;
        for (int k = 0; k < LINE_W / 32; k++) l[k*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        cacheMissFetch  = 1'b0;
        cacheMissMemory = 1'b0;
        dCacheEvict     = 1'b0;
        instrAddr       = '0;
        dataAddr        = '0;
        evictAddr       = '0;
        dCacheOut       = '0;
        memAck          = 1'b0;
        memRData        = '0;
        tick();
        tick();
        rst        = 1'b0;
        m_last_d   = 1'b0;
        exp_i_line = '0;
        exp_d_line = '0;
        exp_q.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_memReq"}, memReq, 1'b0);
        chk({tag, "_memWe"}, memWe, 1'b0);
        chk({tag, "_memAddr"}, memAddr, '0);
        chk({tag, "_memWData"}, memWData, '0);
        chk({tag, "_strobes"}, {evictDone, mcInstrValid, mcDataValid}, '0);
        chk({tag, "_instr_line"}, mcInstrIn, '0);
        chk({tag, "_data_line"}, mcDataIn, '0);
        chk({tag, "_exc"}, {exception, exCause, exAddr}, '0);
    endtask

    // ---------------- reference model ----------------
    // kind: 1 = evict, 2 = instruction fill, 3 = data fill
    task automatic predict();
        logic [1:0]  k;
        logic [31:0] a;
        k = 2'd0;
        a = '0;
        if (dCacheEvict) begin
            k = 2'd1; a = evictAddr;
        end else if (cacheMissMemory && (!cacheMissFetch || !m_last_d)) begin
            k = 2'd3; a = dataAddr;
        end else if (cacheMissFetch) begin
            k = 2'd2; a = instrAddr;
        end
        exp_q.push_back({k, a});
    endtask

    // One full transaction: grant edge, lat wait cycles, ack, completion cycle.
    task automatic serve(input int lat, input logic [LINE_W-1:0] rd);
        logic [33:0] e;
        logic [1:0]  k;
        predict();
        e = exp_q.pop_front();
        k = e[33:32];
        if (k == 2'd1) exp_wdata = dCacheOut;
        tick();
        chk("grant_req", memReq, 1'b1);
        chk("grant_addr", memAddr, e[31:0] & ALIGN);
        chk("grant_we", memWe, logic'(k == 2'd1));
        chk("grant_strobes", {evictDone, mcInstrValid, mcDataValid}, '0);
        dCacheOut = rand_line();
        for (int i = 0; i < lat; i++) begin
            tick();
            chk("hold_req", memReq, 1'b1);
            chk("hold_addr", memAddr, e[31:0] & ALIGN);
        end
        if (k == 2'd1) chk("wdata", memWData, exp_wdata);
        memAck   = 1'b1;
        memRData = rd;
        tick();
        memAck   = 1'b0;
        memRData = rand_line();
        chk("done_req", memReq, 1'b0);
        chk("evict_done", evictDone, logic'(k == 2'd1));
        chk("instr_valid", mcInstrValid, logic'(k == 2'd2));
        chk("data_valid", mcDataValid, logic'(k == 2'd3));
        if (k == 2'd2) exp_i_line = rd;
        if (k == 2'd3) exp_d_line = rd;
        chk("instr_line", mcInstrIn, exp_i_line);
        chk("data_line", mcDataIn, exp_d_line);
        chk("no_exception", exception, 1'b0);
        case (k)
            2'd1: dCacheEvict = 1'b0;
            2'd2: begin cacheMissFetch = 1'b0; m_last_d = 1'b0; end
            2'd3: begin cacheMissMemory = 1'b0; m_last_d = 1'b1; end
            default: ;
        endcase
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        do_reset();
        chk_all_zero("reset");

        // Ack while idle is ignored.
        memAck   = 1'b1;
        memRData = rand_line();
        tick();
        memAck = 1'b0;
        tick();
        chk("idle_ack_strobes", {evictDone, mcInstrValid, mcDataValid}, '0);
        chk("idle_ack_req", memReq, 1'b0);
        chk("idle_ack_line", mcInstrIn, '0);

        // Fetch miss at 0x44, ack on the third memReq cycle.
        for (int k = 0; k < LINE_W / 32; k++) line_a[k*32 +: 32] = 32'hF800_0600 + k;
        cacheMissFetch = 1'b1;
        instrAddr      = 32'h0000_0044;
        serve(2, line_a);
        tick();
        chk("instr_pulse_single", mcInstrValid, 1'b0);
        chk("instr_line_hold", mcInstrIn, line_a);

        // Simultaneous eviction and data miss: writeback goes first.
        dCacheEvict     = 1'b1;
        evictAddr       = 32'h0000_2000;
        dCacheOut       = rand_line();
        cacheMissMemory = 1'b1;
        dataAddr        = 32'h0000_3000;
        serve(1, rand_line());
        serve(3, rand_line());

        // Both fills held together from reset: D, I, D, I.
        do_reset();
        cacheMissFetch  = 1'b1;
        instrAddr       = 32'h0000_0104;
        cacheMissMemory = 1'b1;
        dataAddr        = 32'h0000_4008;
        for (int t = 0; t < 4; t++) begin
            serve($urandom_range(0, 4), rand_line());
            cacheMissFetch  = 1'b1;
            cacheMissMemory = 1'b1;
        end
        cacheMissFetch  = 1'b0;
        cacheMissMemory = 1'b0;
        tick();

        // Randomized mix of requests checked against the model.
        for (int t = 0; t < 40; t++) begin
            if (!dCacheEvict && ($urandom_range(0, 3) == 0)) begin
                dCacheEvict = 1'b1;
                evictAddr   = $urandom;
                dCacheOut   = rand_line();
            end
            if (!cacheMissFetch && ($urandom_range(0, 1) == 1)) begin
                cacheMissFetch = 1'b1;
                instrAddr      = $urandom;
            end
            if (!cacheMissMemory && ($urandom_range(0, 1) == 1)) begin
                cacheMissMemory = 1'b1;
                dataAddr        = $urandom | 32'h0010_0000;
            end
            if (!(dCacheEvict || cacheMissFetch || cacheMissMemory)) begin
                cacheMissFetch = 1'b1;
                instrAddr      = $urandom;
            end
            serve($urandom_range(0, 6), rand_line());
        end

        // Protection: last byte of the static region faults.
        do_reset();
        cacheMissMemory = 1'b1;
        dataAddr        = 32'h0001_FFFF;
        tick();
        chk("prot_limit_exc", {exception, exCause}, 3'b101);
        chk("prot_limit_addr", exAddr, 32'h0001_FFFF);
        chk("prot_limit_req", memReq, 1'b0);

        // Just outside the region on either side: normal fills.
        do_reset();
        cacheMissMemory = 1'b1;
        dataAddr        = 32'h0000_FFFF;
        serve(1, rand_line());
        cacheMissMemory = 1'b1;
        dataAddr        = 32'h0002_0000;
        serve(0, rand_line());

        // First byte of the region faults, then HALTED ignores everything.
        cacheMissMemory = 1'b1;
        dataAddr        = 32'h0001_0000;
        tick();
        chk("prot_base_exc", {exception, exCause}, 3'b101);
        chk("prot_base_addr", exAddr, 32'h0001_0000);
        chk("prot_base_req", memReq, 1'b0);
        cacheMissMemory = 1'b0;
        cacheMissFetch  = 1'b1;
        instrAddr       = 32'h0000_0080;
        for (int i = 0; i < 12; i++) begin
            memAck = 1'($urandom_range(0, 1));
            tick();
            chk("halted_req", memReq, 1'b0);
            chk("halted_strobes", {evictDone, mcInstrValid, mcDataValid}, '0);
            chk("halted_exc", {exception, exCause}, 3'b101);
        end
        memAck = 1'b0;

        // Watchdog expiry: memReq held 8 cycles, then timeout exception.
        do_reset();
        cacheMissFetch = 1'b1;
        instrAddr      = 32'h1234_5678;
        tick();
        chk("to_req_first", memReq, 1'b1);
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            tick();
            chk("to_req_hold", memReq, 1'b1);
            chk("to_no_exc", exception, 1'b0);
        end
        tick();
        chk("to_req_drop", memReq, 1'b0);
        chk("to_exc", {exception, exCause}, 3'b110);
        chk("to_addr", exAddr, 32'h1234_5640);
        chk("to_no_valid", mcInstrValid, 1'b0);
        memAck = 1'b1;
        tick();
        memAck = 1'b0;
        tick();
        chk("to_late_ack", {memReq, mcInstrValid}, 2'b00);

        // Ack on the last watchdog cycle completes normally.
        do_reset();
        cacheMissFetch = 1'b1;
        instrAddr      = 32'h0000_8000;
        serve(TIMEOUT - 1, rand_line());

        // Reset while a data fill is outstanding.
        do_reset();
        cacheMissMemory = 1'b1;
        dataAddr        = 32'h0000_5000;
        serve(1, rand_line());
        cacheMissMemory = 1'b1;
        dataAddr        = 32'h0000_7000;
        tick();
        chk("mid_req", memReq, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("mid_reset");
        tick();
        rst             = 1'b0;
        cacheMissMemory = 1'b0;
        m_last_d        = 1'b0;
        exp_i_line      = '0;
        exp_d_line      = '0;
        cacheMissFetch  = 1'b1;
        instrAddr       = 32'h0000_6010;
        serve(2, rand_line());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
